axi_lite_master: RTL and testbench

- Bridge from a simple stream-style command port (tvalid/tready, tdata, tkeep) to an AXI4-Lite master interface.
- Each accepted beat carries an address and, optionally, data:
  - Full tkeep issues one AXI-Lite write.
  - Partial tkeep (address byte(s) only) issues one AXI-Lite read.
- Sits between a command generator and an AXI-Lite slave or interconnect.
- Exactly one transaction is outstanding at a time.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_master.sv | 176 +++++++++++++++++
 tb/tb_axi_lite_master.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared state encoding and AXI response codes for the stream-to-AXI-Lite command bridge.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return !((resp == RESP_OKAY) || (resp == RESP_EXOKAY));
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Bridges a tvalid/tready command stream onto an AXI4-Lite master port, one
// transaction outstanding at a time; full tkeep means write, anything else means read.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 8,
    parameter int BYTE_WD = (ADDR_WD + DATA_WD) >> 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [BYTE_WD-1:0]         tkeep,
    input  logic [ADDR_WD+DATA_WD-1:0] tdata,
    input  logic                       tvalid,
    output logic                       tready,
    output logic [ADDR_WD-1:0]         awaddr,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [DATA_WD-1:0]         wdata,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready,
    output logic [ADDR_WD-1:0]         araddr,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic                       rvalid,
    input  logic [DATA_WD-1:0]         rdata,
    input  logic [1:0]                 rresp,
    output logic                       rready
);

    state_e               state_r;
    logic                 aw_done_r;
    logic                 w_done_r;
    logic [1:0]           bresp_r;
    logic [DATA_WD-1:0]   rdata_r;
    logic [1:0]           rresp_r;
    logic                 resp_err_r;

    logic                 tfire_s;
    logic                 aw_fire_s;
    logic                 w_fire_s;
    logic                 b_fire_s;
    logic                 ar_fire_s;
    logic                 r_fire_s;
    logic                 aw_done_s;
    logic                 w_done_s;
    logic                 is_write_s;
    logic [ADDR_WD-1:0]   cmd_addr_s;
    logic [DATA_WD-1:0]   cmd_data_s;
    logic                 unused_capture_s;

    assign tfire_s    = tvalid & tready;
    assign aw_fire_s  = awvalid & awready;
    assign w_fire_s   = wvalid & wready;
    assign b_fire_s   = bvalid & bready;
    assign ar_fire_s  = arvalid & arready;
    assign r_fire_s   = rvalid & rready;
    assign is_write_s = &tkeep;
    assign cmd_addr_s = tdata[ADDR_WD-1:0];
    assign cmd_data_s = tdata[ADDR_WD+DATA_WD-1:ADDR_WD];

    // A channel counts as done if it fired earlier or fires on this edge.
    assign aw_done_s  = aw_done_r | aw_fire_s;
    assign w_done_s   = w_done_r | w_fire_s;

    // Read/write responses are captured for debug visibility only; nothing leaves the block.
    assign unused_capture_s = ^{bresp_r, rdata_r, rresp_r, resp_err_r};

    // Transaction sequencer: owns the state and every registered output.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= IDLE;
            tready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= {ADDR_WD{1'b0}};
            wdata      <= {DATA_WD{1'b0}};
            araddr     <= {ADDR_WD{1'b0}};
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            rdata_r    <= {DATA_WD{1'b0}};
            rresp_r    <= RESP_OKAY;
            resp_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tfire_s) begin
                        tready <= 1'b0;
                        if (is_write_s) begin
                            awaddr    <= cmd_addr_s;
                            wdata     <= cmd_data_s;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                            state_r   <= WR;
                        end else begin
                            araddr  <= cmd_addr_s;
                            arvalid <= 1'b1;
                            state_r <= RD_ADDR;
                        end
                    end else begin
                        tready <= 1'b1;
                    end
                end

                WR: begin
                    if (aw_fire_s) begin
                        awvalid <= 1'b0;
                    end
                    if (w_fire_s) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready    <= 1'b1;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        state_r   <= WR_RESP;
                    end else begin
                        aw_done_r <= aw_done_s;
                        w_done_r  <= w_done_s;
                    end
                end

                WR_RESP: begin
                    if (b_fire_s) begin
                        bready     <= 1'b0;
                        tready     <= 1'b1;
                        bresp_r    <= bresp;
                        resp_err_r <= resp_err_r | resp_is_error(bresp);
                        state_r    <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (ar_fire_s) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_r <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (r_fire_s) begin
                        rready     <= 1'b0;
                        tready     <= 1'b1;
                        rdata_r    <= rdata;
                        rresp_r    <= rresp;
                        resp_err_r <= resp_err_r | resp_is_error(rresp);
                        state_r    <= IDLE;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    tready    <= 1'b0;
                    awvalid   <= 1'b0;
                    wvalid    <= 1'b0;
                    bready    <= 1'b0;
                    arvalid   <= 1'b0;
                    rready    <= 1'b0;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: table-driven commands, a responsive
// AXI-Lite slave with stall modes, and a scoreboard of expected AW/W/AR beats.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [BW-1:0] tkeep;
    logic [15:0]   tdata;
    logic          tvalid, tready;
    logic [7:0]    awaddr, wdata, araddr, rdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_master #(.DATA_WD(DW), .ADDR_WD(AW)) dut (
        .clk(clk), .rstn(rstn), .tkeep(tkeep), .tdata(tdata), .tvalid(tvalid), .tready(tready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  keep;
        logic [15:0] tdata;
        logic [7:0]  rdata;
        logic [1:0]  resp;
        bit          wr;
        logic [7:0]  ea;
        logic [7:0]  ed;
    } vec_t;

    exp_t aw_q[$];
    exp_t w_q[$];
    exp_t ar_q[$];

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs: 0 = always ready, 1 = random, 2 = held low.
    int         aw_mode = 0, w_mode = 0, ar_mode = 0;
    bit         b_rand = 1'b0, r_rand = 1'b0;
    logic [1:0] cur_bresp = RESP_OKAY, cur_rresp = RESP_OKAY;
    logic [7:0] cur_rdata = 8'h00;

    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int cyc = 0, tfire_cyc = 0, aw_cyc = 0, ar_cyc = 0, done_cyc = 0;
    bit busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic rdy(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(1, 0));
            default: return 1'b0;
        endcase
    endfunction

    // Monitor + scoreboard at negedge, slave response update just after posedge.
    initial begin
        logic aw_f, w_f, b_f, ar_f, r_f, rst_seen;
        logic p_awv, p_wv, p_arv;
        logic [7:0] p_awaddr, p_wdata, p_araddr;
        bit mon_aw_done, mon_w_done, sg_aw, sg_w, r_owed;
        exp_t e;
        p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
        p_awaddr = 8'h00; p_wdata = 8'h00; p_araddr = 8'h00;
        mon_aw_done = 1'b0; mon_w_done = 1'b0; sg_aw = 1'b0; sg_w = 1'b0; r_owed = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            rst_seen = !rstn;
            aw_f = 1'b0; w_f = 1'b0; b_f = 1'b0; ar_f = 1'b0; r_f = 1'b0;
            if (!rstn) begin
                p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
                busy = 1'b0; mon_aw_done = 1'b0; mon_w_done = 1'b0;
            end else begin
                aw_f = awvalid && awready;
                w_f  = wvalid && wready;
                b_f  = bvalid && bready;
                ar_f = arvalid && arready;
                r_f  = rvalid && rready;
                if (p_awv) begin
                    chk("awvalid_hold", awvalid, 1);
                    chk("awaddr_stable", awaddr, p_awaddr);
                end
                if (p_wv) begin
                    chk("wvalid_hold", wvalid, 1);
                    chk("wdata_stable", wdata, p_wdata);
                end
                if (p_arv) begin
                    chk("arvalid_hold", arvalid, 1);
                    chk("araddr_stable", araddr, p_araddr);
                end
                if (busy) chk("tready_low_busy", tready, 0);
                if (bready) chk("bready_after_aw_w", mon_aw_done && mon_w_done, 1);
                if (aw_f) begin
                    aw_cnt++; aw_cyc = cyc; mon_aw_done = 1'b1;
                    if (aw_q.size() == 0) fail_now("aw_unexpected");
                    else begin e = aw_q.pop_front(); chk("awaddr", awaddr, e.addr); end
                end
                if (w_f) begin
                    w_cnt++; mon_w_done = 1'b1;
                    if (w_q.size() == 0) fail_now("w_unexpected");
                    else begin e = w_q.pop_front(); chk("wdata", wdata, e.data); end
                end
                if (ar_f) begin
                    ar_cnt++; ar_cyc = cyc;
                    if (ar_q.size() == 0) fail_now("ar_unexpected");
                    else begin e = ar_q.pop_front(); chk("araddr", araddr, e.addr); end
                end
                if (b_f) begin
                    b_cnt++; done_cyc = cyc; mon_aw_done = 1'b0; mon_w_done = 1'b0;
                end
                if (r_f) begin
                    r_cnt++; done_cyc = cyc;
                end
                if (b_f || r_f) busy = 1'b0;
                if (tvalid && tready) begin busy = 1'b1; tfire_cyc = cyc; end
                p_awv = awvalid && !aw_f; p_awaddr = awaddr;
                p_wv  = wvalid && !w_f;   p_wdata  = wdata;
                p_arv = arvalid && !ar_f; p_araddr = araddr;
            end
            @(posedge clk);
            #1;
            if (rst_seen) begin
                awready = 1'b0; wready = 1'b0; arready = 1'b0;
                bvalid = 1'b0; rvalid = 1'b0;
                sg_aw = 1'b0; sg_w = 1'b0; r_owed = 1'b0;
            end else begin
                if (aw_f) sg_aw = 1'b1;
                if (w_f) sg_w = 1'b1;
                if (b_f) bvalid = 1'b0;
                if (sg_aw && sg_w && !bvalid && (!b_rand || $urandom_range(1, 0) == 1)) begin
                    bvalid = 1'b1; bresp = cur_bresp; sg_aw = 1'b0; sg_w = 1'b0;
                end
                if (r_f) rvalid = 1'b0;
                if (ar_f) r_owed = 1'b1;
                if (r_owed && !rvalid && (!r_rand || $urandom_range(1, 0) == 1)) begin
                    rvalid = 1'b1; rdata = cur_rdata; rresp = cur_rresp; r_owed = 1'b0;
                end
                awready = rdy(aw_mode);
                wready  = rdy(w_mode);
                arready = rdy(ar_mode);
            end
        end
    end

    // Drive one command; expectations are queued as it is presented.
    task automatic send(input logic [1:0] keep, input logic [15:0] data, input bit wr,
                        input logic [7:0] ea, input logic [7:0] ed, input bit drop);
        exp_t e;
        bit ok;
        e.addr = ea;
        e.data = ed;
        @(posedge clk);
        #1;
        tvalid = 1'b1; tkeep = keep; tdata = data;
        if (wr) begin aw_q.push_back(e); w_q.push_back(e); end
        else ar_q.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = tready;
        end
        if (!ok) fail_now("send_timeout");
        @(posedge clk);
        #1;
        if (drop) tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = tready;
        end
        if (!ok) fail_now({name, "_idle_timeout"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int aw0, w0, b0, ar0, r0;
        bit ok;
        vecs[0] = '{2'b11, 16'h5A03, 8'h00, RESP_OKAY,   1'b1, 8'h03, 8'h5A};
        vecs[1] = '{2'b01, 16'hFF10, 8'h07, RESP_OKAY,   1'b0, 8'h10, 8'h00};
        vecs[2] = '{2'b11, 16'hC3F0, 8'h00, RESP_SLVERR, 1'b1, 8'hF0, 8'hC3};
        vecs[3] = '{2'b01, 16'h0044, 8'h99, RESP_DECERR, 1'b0, 8'h44, 8'h00};
        vecs[4] = '{2'b10, 16'h1234, 8'h5E, RESP_OKAY,   1'b0, 8'h34, 8'h00};
        vecs[5] = '{2'b00, 16'hA5FF, 8'h01, RESP_OKAY,   1'b0, 8'hFF, 8'h00};

        rstn = 1'b0; tvalid = 1'b0; tkeep = 2'b00; tdata = 16'h0000;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; bresp = RESP_OKAY; rresp = RESP_OKAY; rdata = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {tready, awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("reset_addr_data", {awaddr, wdata, araddr}, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("tready_after_reset", tready, 1);

        // Basic writes/reads, including error responses and partial tkeep patterns.
        for (int k = 0; k < 6; k++) begin
            cur_bresp = vecs[k].resp; cur_rresp = vecs[k].resp; cur_rdata = vecs[k].rdata;
            aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
            send(vecs[k].keep, vecs[k].tdata, vecs[k].wr, vecs[k].ea, vecs[k].ed, 1'b1);
            wait_idle($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_aw_cnt", k), aw_cnt - aw0, vecs[k].wr ? 1 : 0);
            chk($sformatf("vec%0d_w_cnt", k), w_cnt - w0, vecs[k].wr ? 1 : 0);
            chk($sformatf("vec%0d_b_cnt", k), b_cnt - b0, vecs[k].wr ? 1 : 0);
            chk($sformatf("vec%0d_ar_cnt", k), ar_cnt - ar0, vecs[k].wr ? 0 : 1);
            chk($sformatf("vec%0d_r_cnt", k), r_cnt - r0, vecs[k].wr ? 0 : 1);
            chk($sformatf("vec%0d_addr_lat", k), (vecs[k].wr ? aw_cyc : ar_cyc) - tfire_cyc, 1);
            chk($sformatf("vec%0d_done_lat", k), done_cyc - tfire_cyc, 2);
        end

        // Skewed write: address accepted while the data channel is stalled.
        cur_bresp = RESP_OKAY;
        w_mode = 2;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        send(2'b11, 16'h6622, 1'b1, 8'h22, 8'h66, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (aw_cnt != aw0);
        end
        if (!ok) fail_now("skew_aw_timeout");
        repeat (2) begin
            @(negedge clk);
            chk("skew_awvalid_clear", awvalid, 0);
            chk("skew_wvalid_hold", wvalid, 1);
            chk("skew_bready_low", bready, 0);
        end
        @(posedge clk);
        #1 w_mode = 0;
        wait_idle("skew");
        chk("skew_aw_cnt", aw_cnt - aw0, 1);
        chk("skew_w_cnt", w_cnt - w0, 1);
        chk("skew_b_cnt", b_cnt - b0, 1);

        // Read with a stalled read-address channel.
        ar_mode = 2; cur_rdata = 8'h07; cur_rresp = RESP_OKAY;
        aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; r0 = r_cnt;
        send(2'b01, 16'hFF10, 1'b0, 8'h10, 8'h00, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("rd_arvalid_hold", arvalid, 1);
            chk("rd_araddr", araddr, 8'h10);
            chk("rd_rready_low", rready, 0);
        end
        @(posedge clk);
        #1 ar_mode = 0;
        wait_idle("rd_stall");
        chk("rd_no_aw", aw_cnt - aw0, 0);
        chk("rd_no_w", w_cnt - w0, 0);
        chk("rd_ar_cnt", ar_cnt - ar0, 1);
        chk("rd_r_cnt", r_cnt - r0, 1);

        // Back-to-back writes with tvalid held high and random stalls everywhere.
        aw_mode = 1; w_mode = 1; b_rand = 1'b1;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a, d;
            a = i[7:0];
            d = 8'hA0 + i[7:0];
            send(2'b11, {d, a}, 1'b1, a, d, i == 3);
        end
        wait_idle("b2b");
        chk("b2b_aw_cnt", aw_cnt - aw0, 4);
        chk("b2b_w_cnt", w_cnt - w0, 4);
        chk("b2b_b_cnt", b_cnt - b0, 4);
        aw_mode = 0; w_mode = 0; b_rand = 1'b0;

        // Reset while the write address is still pending.
        aw_mode = 2;
        aw0 = aw_cnt;
        send(2'b11, 16'hBB55, 1'b1, 8'h55, 8'hBB, 1'b1);
        @(negedge clk);
        chk("rst_pre_awvalid", awvalid, 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ctrl", {tready, awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rst_mid_no_aw", aw_cnt - aw0, 0);
        aw_q.delete(); w_q.delete(); ar_q.delete();
        aw_mode = 0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_tready", tready, 1);
        aw0 = aw_cnt; b0 = b_cnt;
        send(2'b11, 16'h7711, 1'b1, 8'h11, 8'h77, 1'b1);
        wait_idle("post_rst");
        chk("post_rst_aw_cnt", aw_cnt - aw0, 1);
        chk("post_rst_b_cnt", b_cnt - b0, 1);

        chk("aw_q_empty", aw_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);
        chk("ar_q_empty", ar_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
